// File: rtl/tcm_sig_dump_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// tcm_sig_pkg
//
// Purpose : shared types and constants for the TCM signature dump controller.
//           Holds the controller FSM state encoding, the word geometry and the
//           default sizing used by tcm_sig_dump_ctrl and tcm_sig_word_asm.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package tcm_sig_pkg;

  // Default sizing: 128 KB TCM byte address space, 1024-cycle read timeout.
  localparam int TCM_ADDR_W_DEF      = 17;
  localparam int TCM_TIMEOUT_CYC_DEF = 1024;
  localparam int TCM_TO_W_DEF        = 11;

  // Word geometry of the emitted signature stream.
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_IDX_W     = 2;
  localparam int WORD_W         = 8 * BYTES_PER_WORD;

  // Controller FSM state; IDLE must stay at encoding 0 so the reset value
  // and the "not busy" state coincide.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_REQ   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_EMIT  = 3'd4,
    ST_FIN   = 3'd5
  } tcm_sig_state_e;

  // A range boundary is usable only if it is word aligned.
  function automatic logic tcm_sig_misaligned(input logic [1:0] addr_lo);
    return (addr_lo != 2'b00);
  endfunction

endpackage : tcm_sig_pkg

// File: rtl/tcm_sig_dump_ctrl_word_asm.sv
// ---------------------------------------------------------------------------
// tcm_sig_word_asm
//
// Purpose : byte-lane assembler for the signature stream. Each returned TCM
//           byte is written into lane i_byte_idx of a 32-bit little-endian
//           word register; the register holds its value otherwise, which keeps
//           the emitted word stable for as long as the sink stalls.
//
// Ports   :
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   i_clr       in   clear the word register (new dump accepted)
//   i_we        in   write i_byte into lane i_byte_idx
//   i_byte_idx  in   byte lane select, 0 = bits [7:0]
//   i_byte      in   byte to write
//   o_word      out  assembled word
// ---------------------------------------------------------------------------
module tcm_sig_word_asm
  import tcm_sig_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clr,
  input  logic                  i_we,
  input  logic [BYTE_IDX_W-1:0] i_byte_idx,
  input  logic [7:0]            i_byte,
  output logic [WORD_W-1:0]     o_word
);

  logic [WORD_W-1:0] r_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= '0;
    end else if (i_clr) begin
      r_word <= '0;
    end else if (i_we) begin
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
        if (i_byte_idx == BYTE_IDX_W'(i)) begin
          r_word[8*i +: 8] <= i_byte;
        end
      end
    end
  end

  assign o_word = r_word;

endmodule : tcm_sig_word_asm

// File: rtl/tcm_sig_dump_ctrl.sv
// ---------------------------------------------------------------------------
// tcm_sig_dump_ctrl
//
// Purpose : after a compliance run, walks the TCM byte range
//           [begin_addr, end_addr), reads it one byte at a time over the TCM
//           read port, assembles little-endian 32-bit words and streams them
//           to the UART/trace sink.
//
// Handshakes:
//   TCM read : mem_req/mem_addr are held stable until mem_gnt is seen high in
//              the same cycle; the request is then accepted. Exactly one read
//              is outstanding; its data arrives with mem_rvalid at the
//              earliest one cycle after the grant.
//   Sink     : sig_valid/sig_data are held stable until sig_ready is seen high
//              in the same cycle; the word is transferred on that edge.
//
// Ports   :
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 one-cycle pulse, latches begin/end (ignored if busy)
//   begin_addr/end_addr   byte range to dump, end exclusive, word aligned
//   mem_req/mem_addr      byte read request and address
//   mem_gnt               read request accepted this cycle
//   mem_rvalid/mem_rdata  read byte return
//   sig_valid/sig_data    assembled word stream
//   sig_ready             sink accepts word
//   busy                  dump in progress
//   done                  one-cycle pulse on normal completion
//   err                   sticky error (bad range or read timeout)
//
// Build option TCM_SIG_DUMP_CNT_EN adds:
//   word_cnt              number of words accepted by the sink this dump
//   abort_addr            read address that timed out
// ---------------------------------------------------------------------------
module tcm_sig_dump_ctrl
  import tcm_sig_pkg::*;
#(
  parameter int ADDR_W      = TCM_ADDR_W_DEF,
  parameter int TIMEOUT_CYC = TCM_TIMEOUT_CYC_DEF,
  // Must satisfy 2**TO_W > TIMEOUT_CYC.
  parameter int TO_W        = TCM_TO_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] begin_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [7:0]        mem_rdata,
  output logic              sig_valid,
  output logic [31:0]       sig_data,
  input  logic              sig_ready,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef TCM_SIG_DUMP_CNT_EN
  ,
  output logic [ADDR_W-3:0] word_cnt,
  output logic [ADDR_W-1:0] abort_addr
`endif
);

  localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(BYTES_PER_WORD);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

  // -------------------------------------------------------------------------
  // State and registered outputs
  // -------------------------------------------------------------------------
  tcm_sig_state_e          r_state;
  logic [ADDR_W-1:0]       r_begin;
  logic [ADDR_W-1:0]       r_end;
  logic [ADDR_W-1:0]       r_cur_addr;
  logic [BYTE_IDX_W-1:0]   r_byte_idx;
  logic [TO_W-1:0]         r_to_cnt;
  logic                    r_mem_req;
  logic [ADDR_W-1:0]       r_mem_addr;
  logic                    r_sig_valid;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_err;
`ifdef TCM_SIG_DUMP_CNT_EN
  logic [ADDR_W-3:0]       r_word_cnt;
  logic [ADDR_W-1:0]       r_abort_addr;
`endif

  // -------------------------------------------------------------------------
  // Address arithmetic. No wrap can occur: CHECK guarantees begin <= end and
  // both are word aligned, so the walk stops exactly at end.
  // -------------------------------------------------------------------------
  logic [BYTE_IDX_W-1:0]   w_next_byte_idx;
  logic [ADDR_W-1:0]       w_next_byte_addr;
  logic [ADDR_W-1:0]       w_next_word_addr;
  logic                    w_range_bad;
  logic                    w_asm_clr;
  logic                    w_asm_we;
  logic [WORD_W-1:0]       w_word;

  assign w_next_byte_idx  = r_byte_idx + BYTE_IDX_W'(1);
  assign w_next_byte_addr = r_cur_addr + {{(ADDR_W-BYTE_IDX_W){1'b0}}, w_next_byte_idx};
  assign w_next_word_addr = r_cur_addr + WORD_STEP;
  assign w_range_bad      = tcm_sig_misaligned(r_begin[1:0]) ||
                            tcm_sig_misaligned(r_end[1:0])   ||
                            (r_begin > r_end);

  // The assembler is cleared when a dump is accepted and written on every
  // returned byte; between those events it holds the word under backpressure.
  assign w_asm_clr = (r_state == ST_IDLE) && start;
  assign w_asm_we  = (r_state == ST_WAIT) && mem_rvalid;

  tcm_sig_word_asm u_word_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_asm_clr),
    .i_we       (w_asm_we),
    .i_byte_idx (r_byte_idx),
    .i_byte     (mem_rdata),
    .o_word     (w_word)
  );

  // -------------------------------------------------------------------------
  // Controller FSM. Every output is a flop updated together with the state
  // transition, so each output is valid for exactly the cycles the FSM spends
  // in the corresponding state.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_begin      <= '0;
      r_end        <= '0;
      r_cur_addr   <= '0;
      r_byte_idx   <= '0;
      r_to_cnt     <= '0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      r_sig_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
`ifdef TCM_SIG_DUMP_CNT_EN
      r_word_cnt   <= '0;
      r_abort_addr <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_begin <= begin_addr;
            r_end   <= end_addr;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_CHECK;
`ifdef TCM_SIG_DUMP_CNT_EN
            r_word_cnt <= '0;
`endif
          end
        end

        ST_CHECK: begin
          if (w_range_bad) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (r_begin == r_end) begin
            r_done  <= 1'b1;
            r_state <= ST_FIN;
          end else begin
            r_cur_addr <= r_begin;
            r_byte_idx <= '0;
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_begin;
            r_state    <= ST_REQ;
          end
        end

        ST_REQ: begin
          if (mem_gnt) begin
            r_mem_req <= 1'b0;
            r_to_cnt  <= '0;
            r_state   <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (mem_rvalid) begin
            if (r_byte_idx == BYTE_IDX_W'(BYTES_PER_WORD - 1)) begin
              r_sig_valid <= 1'b1;
              r_state     <= ST_EMIT;
            end else begin
              r_byte_idx <= w_next_byte_idx;
              r_mem_req  <= 1'b1;
              r_mem_addr <= w_next_byte_addr;
              r_state    <= ST_REQ;
            end
          end else if (r_to_cnt == TO_LAST) begin
            // The counter starts at 0 on the first WAIT cycle, so reaching
            // TIMEOUT_CYC-1 here means TIMEOUT_CYC cycles without data.
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
`ifdef TCM_SIG_DUMP_CNT_EN
            r_abort_addr <= r_mem_addr;
`endif
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end

        ST_EMIT: begin
          if (sig_ready) begin
            r_sig_valid <= 1'b0;
            r_cur_addr  <= w_next_word_addr;
            r_byte_idx  <= '0;
`ifdef TCM_SIG_DUMP_CNT_EN
            r_word_cnt  <= r_word_cnt + (ADDR_W-2)'(1);
`endif
            if (w_next_word_addr == r_end) begin
              r_done  <= 1'b1;
              r_state <= ST_FIN;
            end else begin
              r_mem_req  <= 1'b1;
              r_mem_addr <= w_next_word_addr;
              r_state    <= ST_REQ;
            end
          end
        end

        ST_FIN: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_mem_req   <= 1'b0;
          r_sig_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign sig_valid = r_sig_valid;
  assign sig_data  = w_word;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
`ifdef TCM_SIG_DUMP_CNT_EN
  assign word_cnt   = r_word_cnt;
  assign abort_addr = r_abort_addr;
`endif

endmodule : tcm_sig_dump_ctrl
